quad_enc_position: RTL and testbench



---
 rtl/quad_enc_position.sv | 239 +++++++++++++++++++++++
 tb/tb_quad_enc_position.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_position.sv
// quad_enc_position
// Decodes one rotary encoder (quadrature A/B plus push-button) into a bounded
// 8-bit position in the range 0..MAX.
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   enc_in    : raw pins, bit 0 = A, bit 1 = B, bit 2 = BTN (active-high)
//   pos       : current position, 0..MAX
//   dir       : 01 = last change was an increment, 10 = decrement,
//               00 = no step since reset or recentre
//   step      : one-cycle pulse when pos changes because of rotation
//   btn_press : one-cycle pulse on the debounced rising edge of BTN
// Each input bit is synchronised, then debounced independently. A quadrature
// FSM on the debounced A/B pair only counts a full detent (11 -> 11 through all
// three intermediate codes). The button recentres the position and wins over a
// coincident count.
module quad_enc_position #(
    parameter int MAX        = 159,
    parameter int CENTER     = 0,
    parameter int WRAP       = 1,
    parameter int DEB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] enc_in,
    output logic [7:0] pos,
    output logic [1:0] dir,
    output logic       step,
    output logic       btn_press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [7:0] MAX_V    = 8'(MAX);
    localparam logic [7:0] CENTER_V = 8'(CENTER);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       deb_r;
    logic [CNT_W-1:0] cnt_r [3];
    state_t           state_r;
    logic [1:0]       ab_s;
    logic             inc_req_s;
    logic             dec_req_s;
    logic             btn_prev_r;
    logic             btn_edge_s;
    logic [7:0]       pos_r;
    logic [1:0]       dir_r;
    logic             step_r;
    logic             btn_press_r;

    // Next position for an increment: wrap to 0 or hold at MAX at the top end.
    function automatic logic [7:0] pos_up(input logic [7:0] p);
        if (p == MAX_V) begin
            return (WRAP != 0) ? 8'd0 : MAX_V;
        end else begin
            return p + 8'd1;
        end
    endfunction

    // Next position for a decrement: wrap to MAX or hold at 0 at the bottom end.
    function automatic logic [7:0] pos_down(input logic [7:0] p);
        if (p == 8'd0) begin
            return (WRAP != 0) ? MAX_V : 8'd0;
        end else begin
            return p - 8'd1;
        end
    endfunction

    // Two-flop synchroniser on every raw pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= enc_in;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: a new level must persist DEB_CYCLES cycles to be taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_r <= 3'b011;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DEB_LAST) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // A in the upper bit so the codes read as "AB".
    assign ab_s       = {deb_r[0], deb_r[1]};
    assign btn_edge_s = deb_r[2] & ~btn_prev_r;

    // Quadrature state machine; only a complete detent reaches CW3/CCW3 -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    case (ab_s)
                        2'b01:   state_r <= ST_CW1;
                        2'b10:   state_r <= ST_CCW1;
                        2'b00:   state_r <= ST_ERR;
                        default: state_r <= ST_IDLE;
                    endcase
                end
                ST_CW1: begin
                    case (ab_s)
                        2'b00:   state_r <= ST_CW2;
                        2'b11:   state_r <= ST_IDLE;
                        2'b10:   state_r <= ST_ERR;
                        default: state_r <= ST_CW1;
                    endcase
                end
                ST_CW2: begin
                    case (ab_s)
                        2'b10:   state_r <= ST_CW3;
                        2'b01:   state_r <= ST_CW1;
                        2'b11:   state_r <= ST_ERR;
                        default: state_r <= ST_CW2;
                    endcase
                end
                ST_CW3: begin
                    case (ab_s)
                        2'b11:   state_r <= ST_IDLE;
                        2'b00:   state_r <= ST_CW2;
                        2'b01:   state_r <= ST_ERR;
                        default: state_r <= ST_CW3;
                    endcase
                end
                ST_CCW1: begin
                    case (ab_s)
                        2'b00:   state_r <= ST_CCW2;
                        2'b11:   state_r <= ST_IDLE;
                        2'b01:   state_r <= ST_ERR;
                        default: state_r <= ST_CCW1;
                    endcase
                end
                ST_CCW2: begin
                    case (ab_s)
                        2'b01:   state_r <= ST_CCW3;
                        2'b10:   state_r <= ST_CCW1;
                        2'b11:   state_r <= ST_ERR;
                        default: state_r <= ST_CCW2;
                    endcase
                end
                ST_CCW3: begin
                    case (ab_s)
                        2'b11:   state_r <= ST_IDLE;
                        2'b00:   state_r <= ST_CCW2;
                        2'b10:   state_r <= ST_ERR;
                        default: state_r <= ST_CCW3;
                    endcase
                end
                ST_ERR: begin
                    if (ab_s == 2'b11) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Count requests are decoded from the completing transition so that pos
    // moves one cycle after the debounced pair returns to 11.
    always_comb begin
        inc_req_s = 1'b0;
        dec_req_s = 1'b0;
        if ((state_r == ST_CW3) && (ab_s == 2'b11)) begin
            inc_req_s = 1'b1;
        end else if ((state_r == ST_CCW3) && (ab_s == 2'b11)) begin
            dec_req_s = 1'b1;
        end else begin
            inc_req_s = 1'b0;
            dec_req_s = 1'b0;
        end
    end

    // Position, direction and pulse outputs; a button edge overrides a count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_r       <= CENTER_V;
            dir_r       <= 2'b00;
            step_r      <= 1'b0;
            btn_press_r <= 1'b0;
            btn_prev_r  <= 1'b0;
        end else begin
            btn_prev_r  <= deb_r[2];
            btn_press_r <= btn_edge_s;
            if (btn_edge_s) begin
                pos_r  <= CENTER_V;
                dir_r  <= 2'b00;
                step_r <= 1'b0;
            end else if (inc_req_s) begin
                pos_r  <= pos_up(pos_r);
                dir_r  <= 2'b01;
                step_r <= (pos_up(pos_r) != pos_r);
            end else if (dec_req_s) begin
                pos_r  <= pos_down(pos_r);
                dir_r  <= 2'b10;
                step_r <= (pos_down(pos_r) != pos_r);
            end else begin
                step_r <= 1'b0;
            end
        end
    end

    assign pos       = pos_r;
    assign dir       = dir_r;
    assign step      = step_r;
    assign btn_press = btn_press_r;

endmodule

// File: tb/tb_quad_enc_position.sv
// Bench for quad_enc_position: two instances share one encoder input stream.
//   dut_a : MAX=159, CENTER=10, WRAP=1
//   dut_b : MAX=119, CENTER=0,  WRAP=0
// A directed vector table, hand-written corner sequences and a randomized run
// checked against a phase-counting reference model.
module tb_quad_enc_position;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] enc;
    logic [7:0] pos_a, pos_b;
    logic [1:0] dir_a, dir_b;
    logic       step_a, step_b, bp_a, bp_b;

    int errors = 0;
    int checks = 0;
    int sa = 0, sb = 0, ba = 0, bb = 0;
    int exp_sa, exp_sb, exp_bt;

    // reference model state
    logic [1:0] m_ab;
    int         m_off;
    bit         m_err;
    int         m_pa, m_pb, m_da, m_db;

    always #5 clk = ~clk;

    quad_enc_position #(.MAX(159), .CENTER(10), .WRAP(1), .DEB_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .enc_in(enc),
        .pos(pos_a), .dir(dir_a), .step(step_a), .btn_press(bp_a)
    );

    quad_enc_position #(.MAX(119), .CENTER(0), .WRAP(0), .DEB_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .enc_in(enc),
        .pos(pos_b), .dir(dir_b), .step(step_b), .btn_press(bp_b)
    );

    // pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (step_a === 1'b1) sa++;
        if (step_b === 1'b1) sb++;
        if (bp_a === 1'b1) ba++;
        if (bp_b === 1'b1) bb++;
    end

    typedef struct {
        logic [2:0] enc;
        int hold;
        int pa; int da; int pb; int db;
        int sa; int sb; int bt;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int pa, input int da, input int pb,
                             input int db, input int esa, input int esb, input int ebt);
        chk({name, ".pos_a"}, 32'(pos_a), pa);
        chk({name, ".dir_a"}, 32'(dir_a), da);
        chk({name, ".pos_b"}, 32'(pos_b), pb);
        chk({name, ".dir_b"}, 32'(dir_b), db);
        chk({name, ".steps_a"}, sa, esa);
        chk({name, ".steps_b"}, sb, esb);
        chk({name, ".btn_a"}, ba, ebt);
        chk({name, ".btn_b"}, bb, ebt);
    endtask

    // drive a raw value for n clock cycles; returns on a falling edge
    task automatic hold(input logic [2:0] v, input int n);
        enc = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic detent(input bit cw);
        if (cw) begin
            hold(3'b010, 10); hold(3'b000, 10); hold(3'b001, 10); hold(3'b011, 10);
        end else begin
            hold(3'b001, 10); hold(3'b000, 10); hold(3'b010, 10); hold(3'b011, 10);
        end
    endtask

    task automatic pulse_rst(input string name);
        rst = 1'b1;
        #1;
        chk({name, ".rst_pos_a"}, 32'(pos_a), 10);
        chk({name, ".rst_dir_a"}, 32'(dir_a), 0);
        chk({name, ".rst_step_a"}, 32'(step_a), 0);
        chk({name, ".rst_btn_a"}, 32'(bp_a), 0);
        chk({name, ".rst_pos_b"}, 32'(pos_b), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---- reference model: quadrature phase arithmetic ----
    function automatic int ph(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of_ph(input int p);
        case (p)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int nxt(input int p, input bit up, input int mx, input bit wrap);
        if (up) return (p == mx) ? (wrap ? 0 : mx) : p + 1;
        else    return (p == 0) ? (wrap ? mx : 0) : p - 1;
    endfunction

    task automatic model_count(input bit up);
        int np;
        np = nxt(m_pa, up, 159, 1'b1);
        if (np != m_pa) exp_sa++;
        m_pa = np;
        m_da = up ? 1 : 2;
        np = nxt(m_pb, up, 119, 1'b0);
        if (np != m_pb) exp_sb++;
        m_pb = np;
        m_db = up ? 1 : 2;
    endtask

    task automatic model_ab(input logic [1:0] v);
        int d;
        if (v == m_ab) return;
        d = (ph(v) - ph(m_ab) + 4) % 4;
        if (!m_err) begin
            if (d == 2) m_err = 1'b1;
            else m_off += (d == 1) ? 1 : -1;
        end
        if (v == 2'b11) begin
            if (!m_err && m_off == 4) model_count(1'b1);
            if (!m_err && m_off == -4) model_count(1'b0);
            m_err = 1'b0;
            m_off = 0;
        end
        m_ab = v;
    endtask

    task automatic model_reset();
        m_ab = 2'b11; m_off = 0; m_err = 1'b0;
        m_pa = 10; m_pb = 0; m_da = 0; m_db = 0;
    endtask

    initial begin
        logic [1:0] ab;
        logic [2:0] raw;
        int         pref;

        // enc = {BTN, B, A}
        tbl[0]  = '{3'b010, 10, 10, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{3'b000, 10, 10, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{3'b001, 10, 10, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{3'b011, 10, 11, 1, 1, 1, 1, 1, 0};
        tbl[4]  = '{3'b001, 10, 11, 1, 1, 1, 1, 1, 0};
        tbl[5]  = '{3'b000, 10, 11, 1, 1, 1, 1, 1, 0};
        tbl[6]  = '{3'b010, 10, 11, 1, 1, 1, 1, 1, 0};
        tbl[7]  = '{3'b011, 10, 10, 2, 0, 2, 2, 2, 0};
        tbl[8]  = '{3'b001, 10, 10, 2, 0, 2, 2, 2, 0};
        tbl[9]  = '{3'b000, 10, 10, 2, 0, 2, 2, 2, 0};
        tbl[10] = '{3'b010, 10, 10, 2, 0, 2, 2, 2, 0};
        tbl[11] = '{3'b011, 10,  9, 2, 0, 2, 3, 2, 0};
        tbl[12] = '{3'b010,  3,  9, 2, 0, 2, 3, 2, 0};
        tbl[13] = '{3'b011, 10,  9, 2, 0, 2, 3, 2, 0};
        tbl[14] = '{3'b010, 10,  9, 2, 0, 2, 3, 2, 0};
        tbl[15] = '{3'b011, 10,  9, 2, 0, 2, 3, 2, 0};
        tbl[16] = '{3'b000, 10,  9, 2, 0, 2, 3, 2, 0};
        tbl[17] = '{3'b011, 10,  9, 2, 0, 2, 3, 2, 0};
        tbl[18] = '{3'b111, 20, 10, 0, 0, 0, 3, 2, 1};
        tbl[19] = '{3'b011, 10, 10, 0, 0, 0, 3, 2, 1};

        rst = 1'b1;
        enc = 3'b011;
        repeat (3) @(negedge clk);
        chk("reset.pos_a", 32'(pos_a), 10);
        chk("reset.dir_a", 32'(dir_a), 0);
        chk("reset.step_a", 32'(step_a), 0);
        chk("reset.btn_a", 32'(bp_a), 0);
        chk("reset.pos_b", 32'(pos_b), 0);
        rst = 1'b0;
        hold(3'b011, 10);

        for (int i = 0; i < 20; i++) begin
            hold(tbl[i].enc, tbl[i].hold);
            check_all($sformatf("vec%0d", i), tbl[i].pa, tbl[i].da, tbl[i].pb, tbl[i].db,
                      tbl[i].sa, tbl[i].sb, tbl[i].bt);
        end
        exp_sa = tbl[19].sa;
        exp_sb = tbl[19].sb;
        exp_bt = tbl[19].bt;

        // wrap at the low end of dut_a, saturation at 0 for dut_b
        repeat (11) detent(1'b0);
        exp_sa += 11;
        check_all("wrap_ccw", 159, 2, 0, 2, exp_sa, exp_sb, exp_bt);
        detent(1'b1);
        exp_sa++; exp_sb++;
        check_all("wrap_cw", 0, 1, 1, 1, exp_sa, exp_sb, exp_bt);
        detent(1'b0);
        exp_sa++; exp_sb++;
        check_all("wrap_back", 159, 2, 0, 2, exp_sa, exp_sb, exp_bt);

        // walk dut_b to its top, then one saturated increment
        repeat (119) detent(1'b1);
        exp_sa += 119; exp_sb += 119;
        check_all("b_top", 118, 1, 119, 1, exp_sa, exp_sb, exp_bt);
        detent(1'b1);
        exp_sa++;
        check_all("sat_top", 119, 1, 119, 1, exp_sa, exp_sb, exp_bt);

        // button edge debounces in the same cycle the CW detent completes
        hold(3'b010, 10); hold(3'b000, 10); hold(3'b001, 10);
        hold(3'b111, 10); hold(3'b011, 10);
        exp_bt++;
        check_all("btn_vs_step", 10, 0, 0, 0, exp_sa, exp_sb, exp_bt);
        detent(1'b1);
        exp_sa++; exp_sb++;
        check_all("after_sim", 11, 1, 1, 1, exp_sa, exp_sb, exp_bt);

        // reset in the middle of a detent
        pulse_rst("rst_a");
        hold(3'b010, 10); hold(3'b000, 10);
        pulse_rst("rst_mid");
        hold(3'b001, 10); hold(3'b011, 10);
        check_all("rst_mid", 10, 0, 0, 0, exp_sa, exp_sb, exp_bt);
        detent(1'b1);
        exp_sa++; exp_sb++;
        check_all("rst_after", 11, 1, 1, 1, exp_sa, exp_sb, exp_bt);

        // randomized run against the phase model
        raw = 3'b011;
        pulse_rst("rnd_start");
        hold(raw, 10);
        model_reset();
        pref = 1;
        for (int e = 0; e < 200; e++) begin
            int r;
            r = $urandom_range(0, 19);
            ab = {raw[0], raw[1]};
            if (r == 0) begin
                pulse_rst("rnd_rst");
                model_reset();
                hold(raw, 10);
                model_ab(ab);
            end else if (r <= 2) begin
                logic [1:0] g;
                logic [1:0] x;
                x = 2'($urandom_range(1, 3));
                g = ab ^ x;
                hold({1'b0, g[0], g[1]}, $urandom_range(1, 3));
                hold(raw, 10);
            end else if (r == 3) begin
                hold({1'b1, raw[1:0]}, 12);
                m_pa = 10; m_pb = 0; m_da = 0; m_db = 0;
                exp_bt++;
                hold(raw, 10);
            end else begin
                if ($urandom_range(0, 5) == 0) pref = -pref;
                if ($urandom_range(0, 9) == 0) ab = ab ^ 2'b11;
                else ab = ab_of_ph((ph(ab) + pref + 4) % 4);
                raw = {1'b0, ab[0], ab[1]};
                hold(raw, 10);
                model_ab(ab);
            end
            check_all($sformatf("rnd%0d", e), m_pa, m_da, m_pb, m_db, exp_sa, exp_sb, exp_bt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
